filter_ctl_packer: RTL

- Assembles a packed array of NUM_ENTRIES filter_ctl_t entries, each ENTRY_W bits, from a stream of single entries.
- It is the write-side counterpart of the struct-array consumers, which index one element out of a packed filter_ctl_t vector.
- It sits between the control-register sequencer and the filter datapath.
- It delivers one complete packed frame per valid/ready transfer.

---
 rtl/filter_ctl_packer.sv | 87 ++++++++
 1 files changed

// File: rtl/filter_ctl_packer.sv
// filter_ctl_packer: gathers a stream of filter_ctl_t entries into one
// packed NUM_ENTRIES-wide frame and hands it off over valid/ready.
module filter_ctl_packer #(
    parameter int                 ENTRY_W     = 10,
    parameter int                 NUM_ENTRIES = 2,
    parameter logic [ENTRY_W-1:0] PAD         = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ENTRY_W-1:0]                 in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_ENTRIES*ENTRY_W-1:0]     out_data,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   out_count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int FRM_W = NUM_ENTRIES * ENTRY_W;
    localparam logic [FRM_W-1:0] PAD_FRAME = {NUM_ENTRIES{PAD}};

    typedef enum logic {FILL, HOLD} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [FRM_W-1:0] acc_q;
    logic [FRM_W-1:0] acc_d;
    logic [FRM_W-1:0] out_data_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_valid_q;
    logic             accept;
    logic             done;

    // out_ready feeds in_ready combinationally so HOLD can retire a frame
    // and take the first entry of the next one in the same cycle.
    assign in_ready = (state_q == FILL) || out_ready;
    assign accept   = in_valid && in_ready;
    assign done     = (idx_q == IDX_W'(NUM_ENTRIES - 1)) || in_last;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                acc_d[i*ENTRY_W +: ENTRY_W] = in_data;
            end
        end
    end

    // While in HOLD, idx_q is 0 and acc_q is all PAD, so an entry taken
    // during the handshake goes through the same path as one in FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            acc_q       <= PAD_FRAME;
            out_data_q  <= PAD_FRAME;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (state_q == HOLD && out_ready) begin
                state_q     <= FILL;
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (done) begin
                    out_data_q  <= acc_d;
                    out_count_q <= CNT_W'(idx_q) + CNT_W'(1);
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                    idx_q       <= '0;
                    acc_q       <= PAD_FRAME;
                end else begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule
